wptr_full_ctrl: RTL and testbench

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/gray2bin_conv.sv | 13 +
 rtl/wptr_full_ctrl.sv | 96 +++++++++
 tb/tb_wptr_full_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer definitions and Gray/binary helpers.
// The helpers take 32-bit operands so any narrower pointer can use them after zero-extension.
package fifo_pkg;

   localparam int ADDR_WIDTH = 9;

   typedef logic [ADDR_WIDTH:0] ptr_t;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 5'd1);
   endfunction

   // Zero-extended Gray input leaves the upper bits zero, so decoding from bit 31 down is width-agnostic
   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Gray-to-binary pointer decoder of configurable width.
module gray2bin_conv
   import fifo_pkg::*;
#(
   parameter int width = ADDR_WIDTH + 1
)(
   input  logic [width-1:0] GRAY,
   output logic [width-1:0] BIN
);

   assign BIN = width'(gray2bin(32'(GRAY)));

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full, level and overflow control for an async FIFO.
// Optional almost-full flag is enabled by defining WPTR_ALMOST_FULL_EN.
module wptr_full_ctrl
   import fifo_pkg::*;
#(
   parameter int addr_width = ADDR_WIDTH,
   parameter int af_thresh  = 2**addr_width - 2
)(
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  WINC,
   input  logic [addr_width:0]   RPTR_SYNC,
   output logic                  WEN,
   output logic [addr_width-1:0] WADDR,
   output logic [addr_width:0]   WPTR,
   output logic                  WFULL,
   output logic [addr_width:0]   WLEVEL,
   output logic                  WOVF,
   output logic                  WALMOST_FULL
);

   localparam int P = addr_width + 1;

   logic [P-1:0] wbin_r;
   logic [P-1:0] wptr_r;
   logic         wfull_r;
   logic [P-1:0] wlevel_r;
   logic         wovf_r;

   logic         wen_s;
   logic [P-1:0] wbin_next_s;
   logic [P-1:0] wgray_next_s;
   logic [P-1:0] rbin_s;
   logic [P-1:0] full_cmp_s;
   logic         wfull_next_s;
   logic [P-1:0] wlevel_next_s;

   gray2bin_conv #(
      .width (P)
   ) u_rptr_dec (
      .GRAY (RPTR_SYNC),
      .BIN  (rbin_s)
   );

   assign wen_s         = WINC & ~wfull_r;
   assign wbin_next_s   = wbin_r + {{addr_width{1'b0}}, wen_s};
   assign wgray_next_s  = P'(bin2gray(32'(wbin_next_s)));
   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal
   assign full_cmp_s    = {~RPTR_SYNC[P-1:P-2], RPTR_SYNC[P-3:0]};
   assign wfull_next_s  = (wgray_next_s == full_cmp_s);
   assign wlevel_next_s = wbin_next_s - rbin_s;

   // Pointer, status and sticky overflow registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wbin_r   <= {P{1'b0}};
         wptr_r   <= {P{1'b0}};
         wfull_r  <= 1'b0;
         wlevel_r <= {P{1'b0}};
         wovf_r   <= 1'b0;
      end else begin
         wbin_r   <= wbin_next_s;
         wptr_r   <= wgray_next_s;
         wfull_r  <= wfull_next_s;
         wlevel_r <= wlevel_next_s;
         wovf_r   <= wovf_r | (WINC & wfull_r);
      end
   end

`ifdef WPTR_ALMOST_FULL_EN
   localparam logic [P-1:0] AF_THRESH_C = P'(af_thresh);

   logic walmost_full_r;

   // Almost-full tracks the same next-state level as WLEVEL
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         walmost_full_r <= 1'b0;
      end else begin
         walmost_full_r <= (wlevel_next_s >= AF_THRESH_C);
      end
   end

   assign WALMOST_FULL = walmost_full_r;
`else
   assign WALMOST_FULL = 1'b0;
`endif

   assign WEN    = wen_s;
   assign WADDR  = wbin_r[addr_width-1:0];
   assign WPTR   = wptr_r;
   assign WFULL  = wfull_r;
   assign WLEVEL = wlevel_r;
   assign WOVF   = wovf_r;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl at addr_width=2, af_thresh=3 (both WPTR_ALMOST_FULL_EN builds).
module tb_wptr_full_ctrl;

   logic       CLK;
   logic       RST_N;
   logic       WINC;
   logic [2:0] RPTR_SYNC;
   logic       WEN;
   logic [1:0] WADDR;
   logic [2:0] WPTR;
   logic       WFULL;
   logic [2:0] WLEVEL;
   logic       WOVF;
   logic       WALMOST_FULL;

   int passed;
   int total;

   // Reference model: plain counts of words written and read
   int m_wcnt;
   int rd_cnt;
   bit m_full;
   bit m_ovf;

   wptr_full_ctrl #(
      .addr_width (2),
      .af_thresh  (3)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .WINC         (WINC),
      .RPTR_SYNC    (RPTR_SYNC),
      .WEN          (WEN),
      .WADDR        (WADDR),
      .WPTR         (WPTR),
      .WFULL        (WFULL),
      .WLEVEL       (WLEVEL),
      .WOVF         (WOVF),
      .WALMOST_FULL (WALMOST_FULL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [2:0] to_gray(input int n);
      logic [2:0] b;
      b = 3'(n % 8);
      return b ^ (b >> 1);
   endfunction

   function automatic logic exp_af(input int lvl);
`ifdef WPTR_ALMOST_FULL_EN
      return (lvl >= 3);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_state(input string tag);
      int lvl;
      lvl = m_wcnt - rd_cnt;
      chk({tag, ".wptr"},   32'(WPTR),         32'(to_gray(m_wcnt)));
      chk({tag, ".waddr"},  32'(WADDR),        32'(m_wcnt % 4));
      chk({tag, ".wfull"},  32'(WFULL),        32'(lvl == 4));
      chk({tag, ".wlevel"}, 32'(WLEVEL),       32'(lvl));
      chk({tag, ".wovf"},   32'(WOVF),         32'(m_ovf));
      chk({tag, ".walmf"},  32'(WALMOST_FULL), 32'(exp_af(lvl)));
   endtask

   // One clock cycle: apply inputs at the falling edge, check WEN, then check registered state
   task automatic step(input string tag, input logic winc, input int rd_adv);
      @(negedge CLK);
      rd_cnt    = rd_cnt + rd_adv;
      WINC      = winc;
      RPTR_SYNC = to_gray(rd_cnt);
      #1;
      chk({tag, ".wen"}, 32'(WEN), 32'(winc && !m_full));
      @(posedge CLK);
      if (winc && m_full) m_ovf = 1'b1;
      else if (winc) m_wcnt = m_wcnt + 1;
      m_full = ((m_wcnt - rd_cnt) == 4);
      #1;
      chk_state(tag);
   endtask

   task automatic model_reset();
      m_wcnt = 0;
      rd_cnt = 0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
   endtask

   initial begin
      int avail;
      passed    = 0;
      total     = 0;
      model_reset();
      RST_N     = 1'b0;
      WINC      = 1'b0;
      RPTR_SYNC = 3'b000;
      repeat (2) @(posedge CLK);
      #1;
      chk_state("reset");
      chk("reset.wen", 32'(WEN), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      // Fill an empty FIFO: Gray sequence 001,011,010,110
      step("fill1", 1'b1, 0);
      chk("fill1.gray", 32'(WPTR), 32'h1);
      step("fill2", 1'b1, 0);
      chk("fill2.gray", 32'(WPTR), 32'h3);
      step("fill3", 1'b1, 0);
      chk("fill3.gray", 32'(WPTR), 32'h2);
      step("fill4", 1'b1, 0);
      chk("fill4.gray", 32'(WPTR), 32'h6);
      chk("fill4.full", 32'(WFULL), 32'd1);
      chk("fill4.level", 32'(WLEVEL), 32'd4);

      // Write while full is dropped and sets the sticky overflow
      step("ovf", 1'b1, 0);
      chk("ovf.gray", 32'(WPTR), 32'h6);
      chk("ovf.flag", 32'(WOVF), 32'd1);

      // Read side advances by one while full
      step("drain", 1'b0, 1);
      chk("drain.full", 32'(WFULL), 32'd0);
      chk("drain.level", 32'(WLEVEL), 32'd3);
      chk("drain.ovf", 32'(WOVF), 32'd1);

      // Simultaneous write and read advance keep the level, then wrap after 8 writes
      step("simul1", 1'b1, 1);
      chk("simul1.level", 32'(WLEVEL), 32'd3);
      step("simul2", 1'b1, 1);
      step("simul3", 1'b1, 1);
      step("simul4", 1'b1, 1);
      chk("wrap.gray", 32'(WPTR), 32'h0);
      chk("wrap.level", 32'(WLEVEL), 32'd3);

      // Asynchronous reset between clock edges
      @(negedge CLK);
      WINC = 1'b0;
      #2;
      RST_N = 1'b0;
      #1;
      model_reset();
      chk_state("areset");
      chk("areset.wen", 32'(WEN), 32'd0);
      RPTR_SYNC = 3'b000;
      @(negedge CLK);
      RST_N = 1'b1;

      // Random traffic with multi-count read jumps
      for (int i = 0; i < 400; i++) begin
         avail = m_wcnt - rd_cnt;
         step("rand", ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, avail)) : 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
